// File: rtl/sys_mem_pkg.sv
// Shared types and constants for the sys_mem block.
package sys_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RSEQ = 2'd1,
        WSEQ = 2'd2
    } burstState_t;

    localparam int          BURST_LEN = 16;
    localparam logic [15:0] OOR_DATA  = 16'hDEAD;

    // Sequential means exactly prev+1; the 16'hFFFF -> 16'h0000 wrap does not qualify.
    function automatic logic isNext(input logic [15:0] prev, input logic [15:0] cur);
        return (prev != 16'hFFFF) && (cur == prev + 16'd1);
    endfunction

endpackage

// File: rtl/sys_mem_if.sv
// Processor-side memory bus for sys_mem.
interface sys_mem_if;
    logic [15:0] Addr;
    logic        RD;
    logic        WR;
    logic [15:0] WData;
    logic [15:0] RData;
    logic        Err;
    logic        BurstDone;

    modport master (output Addr, RD, WR, WData, input RData, Err, BurstDone);
    modport slave  (input Addr, RD, WR, WData, output RData, Err, BurstDone);
endinterface

// File: rtl/sys_mem_array.sv
// Single-port synchronous word storage with a registered read port.
module sys_mem_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              Clk1,
    input  logic              Reset,
    input  logic              wrEn,
    input  logic              rdEn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Storage has no reset; only the read register clears.
    always_ff @(posedge Clk1) begin
        if (wrEn) mem[addr] <= wdata;
    end

    always_ff @(posedge Clk1) begin
        if (Reset)     rdata <= '0;
        else if (rdEn) rdata <= mem[addr];
    end

endmodule

// File: rtl/sys_mem.sv
// Processor memory: address decode, error pulses and burst tracking around sys_mem_array.
// Optional write protection below WPROT_TOP is enabled by defining SYS_MEM_WPROT_EN.
module sys_mem
    import sys_mem_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [15:0] WPROT_TOP = 16'h0040
) (
    input  logic       Clk1,
    input  logic       Reset,
    sys_mem_if.slave   bus
);

    localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

    logic        access, conflict, oor, prot, accErr;
    logic        rdReq, memWe, memRe;
    logic        oorHold;
    logic [15:0] arrRData;
    burstState_t state, dirState;
    logic [3:0]  count;
    logic [15:0] prevAddr;
    logic        errQ, burstDoneQ;

    assign access   = bus.RD | bus.WR;
    assign conflict = bus.RD & bus.WR;
    assign oor      = (bus.Addr >> ADDR_W) != 16'h0000;
    assign rdReq    = bus.RD & ~bus.WR;

`ifdef SYS_MEM_WPROT_EN
    assign prot = bus.WR & (bus.Addr < WPROT_TOP);
`else
    logic unusedWprot;
    assign unusedWprot = ^WPROT_TOP;
    assign prot        = 1'b0;
`endif

    assign accErr   = access & (oor | conflict | prot);
    assign memWe    = bus.WR & ~oor & ~prot & ~Reset;
    assign memRe    = rdReq & ~oor & ~Reset;
    assign dirState = bus.WR ? WSEQ : RSEQ;

    sys_mem_array #(.ADDR_W(ADDR_W), .DATA_W(16)) uArray (
        .Clk1  (Clk1),
        .Reset (Reset),
        .wrEn  (memWe),
        .rdEn  (memRe),
        .addr  (bus.Addr[ADDR_W-1:0]),
        .wdata (bus.WData),
        .rdata (arrRData)
    );

    // Out-of-range reads leave the array register alone and select the marker instead.
    always_ff @(posedge Clk1) begin
        if (Reset)      oorHold <= 1'b0;
        else if (rdReq) oorHold <= oor;
    end

    assign bus.RData = oorHold ? OOR_DATA : arrRData;

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state      <= IDLE;
            count      <= '0;
            prevAddr   <= '0;
            errQ       <= 1'b0;
            burstDoneQ <= 1'b0;
        end else begin
            errQ       <= accErr;
            burstDoneQ <= 1'b0;
            if (accErr) begin
                state <= IDLE;
                count <= '0;
            end else if (access) begin
                prevAddr <= bus.Addr;
                if (state == dirState && isNext(prevAddr, bus.Addr)) begin
                    if (count == LAST_BEAT) begin
                        burstDoneQ <= 1'b1;
                        state      <= IDLE;
                        count      <= '0;
                    end else begin
                        count <= count + 4'd1;
                    end
                end else begin
                    state <= dirState;
                    count <= 4'd1;
                end
            end
            // Idle cycles hold the run so beat gaps do not break a burst.
        end
    end

    assign bus.Err       = errQ;
    assign bus.BurstDone = burstDoneQ;

endmodule
